// File: rtl/hash_table_pkg.sv
// Shared hash-table definitions: default widths, head-table RAM word and FSM state.
package hash_table_pkg;

  localparam int BUCKET_WIDTH_DEF   = 8;
  localparam int HEAD_PTR_WIDTH_DEF = 10;

  typedef struct packed {
    logic                          ptr_val;
    logic [HEAD_PTR_WIDTH_DEF-1:0] ptr;
  } head_ram_data_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } head_table_state_t;

endpackage

// File: rtl/head_table_if.sv
// Write/read port bundle of the head table (writes from the update stage, reads from the engines).
interface head_table_if #(
  parameter int BUCKET_WIDTH   = 8,
  parameter int HEAD_PTR_WIDTH = 10
);

  // No valid/ready handshake: a strobe is taken in any cycle where ready_o=1;
  // a read strobe in cycle N is answered with rd_data_val_o=1 in cycle N+1.
  logic [BUCKET_WIDTH-1:0]   wr_addr_i;
  logic [HEAD_PTR_WIDTH-1:0] wr_data_ptr_i;
  logic                      wr_data_ptr_val_i;
  logic                      wr_en_i;
  logic [BUCKET_WIDTH-1:0]   rd_addr_i;
  logic                      rd_en_i;
  logic [HEAD_PTR_WIDTH-1:0] rd_data_ptr_o;
  logic                      rd_data_ptr_val_o;
  logic                      rd_data_val_o;
  logic                      ready_o;

  modport master (
    output wr_addr_i, wr_data_ptr_i, wr_data_ptr_val_i, wr_en_i, rd_addr_i, rd_en_i,
    input  rd_data_ptr_o, rd_data_ptr_val_o, rd_data_val_o, ready_o
  );

  modport slave (
    input  wr_addr_i, wr_data_ptr_i, wr_data_ptr_val_i, wr_en_i, rd_addr_i, rd_en_i,
    output rd_data_ptr_o, rd_data_ptr_val_o, rd_data_val_o, ready_o
  );

endinterface

// File: rtl/head_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
module head_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Output register clears on reset and holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/head_table.sv
// Bucket-indexed head-pointer table with post-reset clearing sweep.
// HEAD_TABLE_WR_BYPASS_EN: same-cycle write+read of one bucket returns the new data.
module head_table
  import hash_table_pkg::*;
#(
  parameter int BUCKET_WIDTH   = BUCKET_WIDTH_DEF,
  parameter int HEAD_PTR_WIDTH = HEAD_PTR_WIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  head_table_if.slave       bus,
  output head_table_state_t state_o
);

  localparam int DW = HEAD_PTR_WIDTH + 1;
  localparam logic [BUCKET_WIDTH:0] LAST_ADDR = {1'b0, {BUCKET_WIDTH{1'b1}}};

  head_table_state_t       r_state;
  logic [BUCKET_WIDTH:0]   r_cnt;
  logic                    r_ready;
  logic                    r_rd_val;

  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic                    w_we;
  logic [BUCKET_WIDTH-1:0] w_waddr;
  logic [DW-1:0]           w_wdata;
  logic [DW-1:0]           w_ram_q;
  logic [DW-1:0]           w_rdata;

  assign w_wr_acc = r_ready & bus.wr_en_i;
  assign w_rd_acc = r_ready & bus.rd_en_i;

  // Sweep owns the write port until the table is cleared.
  always_comb begin
    w_we    = w_wr_acc;
    w_waddr = bus.wr_addr_i;
    w_wdata = {bus.wr_data_ptr_val_i, bus.wr_data_ptr_i};
    if (r_state == INIT) begin
      w_we    = 1'b1;
      w_waddr = r_cnt[BUCKET_WIDTH-1:0];
      w_wdata = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_cnt == LAST_ADDR || r_cnt[BUCKET_WIDTH]) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        READY: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= INIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_val <= 1'b0;
    end else begin
      r_rd_val <= w_rd_acc;
    end
  end

  head_ram #(
    .ADDR_WIDTH (BUCKET_WIDTH),
    .DATA_WIDTH (DW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_acc),
    .i_raddr (bus.rd_addr_i),
    .o_rdata (w_ram_q)
  );

`ifdef HEAD_TABLE_WR_BYPASS_EN
  logic          r_byp;
  logic [DW-1:0] r_byp_data;

  // Bypass select and data only change on an accepted read, so output holds like the RAM register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_byp      <= 1'b0;
      r_byp_data <= '0;
    end else if (w_rd_acc) begin
      r_byp      <= w_wr_acc && (bus.wr_addr_i == bus.rd_addr_i);
      r_byp_data <= {bus.wr_data_ptr_val_i, bus.wr_data_ptr_i};
    end
  end

  assign w_rdata = r_byp ? r_byp_data : w_ram_q;
`else
  assign w_rdata = w_ram_q;
`endif

  assign bus.rd_data_ptr_val_o = w_rdata[DW-1];
  assign bus.rd_data_ptr_o     = w_rdata[HEAD_PTR_WIDTH-1:0];
  assign bus.rd_data_val_o     = r_rd_val;
  assign bus.ready_o           = r_ready;
  assign state_o               = r_state;

endmodule

// File: tb/tb_head_table.sv
// Self-checking bench for head_table with a behavioural array model of the table.
module tb_head_table;
  import hash_table_pkg::*;

  localparam int BW    = 4;
  localparam int PW    = 10;
  localparam int DEPTH = 1 << BW;

  logic              clk;
  logic              rst;
  head_table_state_t state;

  head_table_if #(.BUCKET_WIDTH(BW), .HEAD_PTR_WIDTH(PW)) bus ();

  head_table #(.BUCKET_WIDTH(BW), .HEAD_PTR_WIDTH(PW)) u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  head_ram_data_t model_mem [DEPTH];
  logic [PW:0]    exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en_i           = 1'b0;
    bus.rd_en_i           = 1'b0;
    bus.wr_addr_i         = '0;
    bus.rd_addr_i         = '0;
    bus.wr_data_ptr_i     = '0;
    bus.wr_data_ptr_val_i = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // Accepted write: model updates once the edge has taken it.
  task automatic drive_write(input int addr, input int ptr, input bit val);
    bus.wr_en_i           = 1'b1;
    bus.wr_addr_i         = BW'(addr);
    bus.wr_data_ptr_i     = PW'(ptr);
    bus.wr_data_ptr_val_i = val;
  endtask

  task automatic drive_read(input int addr);
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = BW'(addr);
  endtask

  // Counts cycles until ready_o rises; bounded.
  task automatic wait_ready(output int cycles, output bit rd_val_seen);
    cycles      = 0;
    rd_val_seen = 1'b0;
    while (!bus.ready_o && cycles < 100) begin
      tick();
      cycles++;
      if (bus.rd_data_val_o) rd_val_seen = 1'b1;
    end
  endtask

  task automatic read_and_check(input string tag, input int addr);
    logic [PW:0] exp;
    idle_inputs();
    drive_read(addr);
    exp = model_mem[addr];
    tick();
    idle_inputs();
    check({tag, "_val"}, 32'(bus.rd_data_val_o), 32'd1);
    check({tag, "_word"}, 32'({bus.rd_data_ptr_val_o, bus.rd_data_ptr_o}), 32'(exp));
  endtask

  initial begin
    int          cyc;
    bit          seen;
    logic [PW:0] held;
    logic [PW:0] exp;
    int          wa, ra;
    head_ram_data_t wd;

    idle_inputs();
    model_clear();
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_rd_val", 32'(bus.rd_data_val_o), 32'd0);
    check("rst_rd_word", 32'({bus.rd_data_ptr_val_o, bus.rd_data_ptr_o}), 32'd0);
    check("rst_state", 32'(state), 32'(INIT));

    // Sweep with strobes asserted; they must be ignored.
    rst = 1'b0;
    drive_write(3, 'h3FF, 1'b1);
    drive_read(3);
    wait_ready(cyc, seen);
    idle_inputs();
    check("sweep_cycles", 32'(cyc), 32'(DEPTH));
    check("sweep_rd_val_quiet", 32'(seen), 32'd0);
    check("sweep_state", 32'(state), 32'(READY));

    for (int i = 0; i < DEPTH; i++) read_and_check("init_clear", i);

    // Write then read next cycle.
    drive_write(5, 'h2A3, 1'b1);
    tick();
    model_mem[5] = {1'b1, 10'h2A3};
    read_and_check("wr_rd_b5", 5);

    // Hold behaviour when no read is issued.
    held = {bus.rd_data_ptr_val_o, bus.rd_data_ptr_o};
    tick();
    check("idle_rd_val", 32'(bus.rd_data_val_o), 32'd0);
    check("idle_hold", 32'({bus.rd_data_ptr_val_o, bus.rd_data_ptr_o}), 32'(held));

    // Same-cycle collision on bucket 7.
    drive_write(7, 'h011, 1'b1);
    tick();
    model_mem[7] = {1'b1, 10'h011};
    drive_write(7, 'h155, 1'b1);
    drive_read(7);
`ifdef HEAD_TABLE_WR_BYPASS_EN
    exp = {1'b1, 10'h155};
`else
    exp = {1'b1, 10'h011};
`endif
    tick();
    idle_inputs();
    model_mem[7] = {1'b1, 10'h155};
    check("coll_val", 32'(bus.rd_data_val_o), 32'd1);
    check("coll_word", 32'({bus.rd_data_ptr_val_o, bus.rd_data_ptr_o}), 32'(exp));
    read_and_check("coll_after", 7);

    // Mid-operation reset with a read on the same edge.
    drive_write(9, 'h100, 1'b1);
    tick();
    model_mem[9] = {1'b1, 10'h100};
    idle_inputs();
    drive_read(9);
    rst = 1'b1;
    tick();
    idle_inputs();
    rst = 1'b0;
    check("midrst_rd_val", 32'(bus.rd_data_val_o), 32'd0);
    check("midrst_ready", 32'(bus.ready_o), 32'd0);
    check("midrst_word", 32'({bus.rd_data_ptr_val_o, bus.rd_data_ptr_o}), 32'd0);
    model_clear();
    wait_ready(cyc, seen);
    check("midrst_cycles", 32'(cyc), 32'(DEPTH));
    read_and_check("midrst_b9", 9);

    // Back-to-back random traffic: one write and one read every cycle.
    for (int n = 0; n < 1000; n++) begin
      wa = $urandom_range(0, DEPTH - 1);
      ra = (($urandom_range(0, 7) == 0)) ? wa : $urandom_range(0, DEPTH - 1);
      wd.ptr     = PW'($urandom_range(0, (1 << PW) - 1));
      wd.ptr_val = 1'($urandom_range(0, 1));
      drive_write(wa, int'(wd.ptr), wd.ptr_val);
      drive_read(ra);
`ifdef HEAD_TABLE_WR_BYPASS_EN
      exp_q.push_back((wa == ra) ? wd : model_mem[ra]);
`else
      exp_q.push_back(model_mem[ra]);
`endif
      tick();
      model_mem[wa] = wd;
      check("b2b_val", 32'(bus.rd_data_val_o), 32'd1);
      check("b2b_word", 32'({bus.rd_data_ptr_val_o, bus.rd_data_ptr_o}), 32'(exp_q.pop_front()));
    end
    idle_inputs();
    tick();
    check("b2b_tail_val", 32'(bus.rd_data_val_o), 32'd0);
    for (int i = 0; i < DEPTH; i++) read_and_check("final_sweep", i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/head_table.md
# head_table

Bucket-indexed head-pointer memory of the hash table. It consumes the write stream produced by the head-table update stage: one bucket's head pointer and valid flag per cycle. It serves single-cycle-latency reads to the lookup/insert/delete engines. After reset it sweeps every bucket to "no chain" before accepting traffic.

## Interface
Parameters:
- BUCKET_WIDTH, 8, bucket address width; table depth is 2**BUCKET_WIDTH.
- HEAD_PTR_WIDTH, 10, width of a head pointer into the data table.

Ports:
- clk_i  in  1  clock. One clock domain; reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- wr_addr_i  in  BUCKET_WIDTH  bucket to write.
- wr_data_ptr_i  in  HEAD_PTR_WIDTH  new head pointer.
- wr_data_ptr_val_i  in  1  new head valid; 0 means the bucket is empty.
- wr_en_i  in  1  write strobe.
- rd_addr_i  in  BUCKET_WIDTH  bucket to read.
- rd_en_i  in  1  read strobe.
- rd_data_ptr_o  out  HEAD_PTR_WIDTH  head pointer read back.
- rd_data_ptr_val_o  out  1  head valid read back.
- rd_data_val_o  out  1  read-data qualifier, one cycle after rd_en_i.
- ready_o  out  1  init sweep done; strobes are accepted only while this is 1.

## Operation
- Each RAM word holds {ptr_val, ptr}, which is HEAD_PTR_WIDTH+1 bits.
- FSM states:
  - INIT: entered on rst_i. An init counter runs 0 to 2**BUCKET_WIDTH-1. Each cycle it writes {0, '0} at the counter address. After the last address the FSM goes to READY.
  - READY: external writes and reads are serviced. This is a terminal state until the next rst_i.
- While in INIT, wr_en_i and rd_en_i are ignored: no RAM write, and rd_data_val_o stays 0. Upstream must hold its strobes until ready_o=1.
- Write in READY: on wr_en_i=1 the RAM word at wr_addr_i takes {wr_data_ptr_val_i, wr_data_ptr_i}.
- Read in READY: on rd_en_i=1 the word at rd_addr_i is returned next cycle, with rd_data_val_o=1.
- Writes and reads may be issued in the same cycle to any addresses. No backpressure; full throughput is one write and one read per cycle.
- Same-cycle write and read to the same address follows the configuration below.
- A write in cycle N followed by a read of the same address in cycle N+1 or later always returns the write-N data.
- The init counter is BUCKET_WIDTH+1 bits wide, so the terminal compare does not wrap. Its MSB, or a compare against the last address, triggers INIT to READY.

## Timing
- Reset values (cycle after rst_i=1): ready_o=0, rd_data_val_o=0, rd_data_ptr_o='0, rd_data_ptr_val_o=0, FSM=INIT, counter=0.
- INIT lasts exactly 2**BUCKET_WIDTH cycles after rst_i deasserts. ready_o rises in the cycle after the last sweep write.
- Read latency is 1 cycle: rd_en_i in cycle N gives rd_data_val_o=1 and the data in cycle N+1.
- rd_data_val_o is 0 in any cycle that does not follow an accepted read.
- rd_data_ptr_o and rd_data_ptr_val_o hold their last value while rd_data_val_o=0.
- rst_i asserted mid-operation, including mid-INIT:
  - The next cycle shows the reset values.
  - The sweep restarts at address 0.
  - An in-flight read is dropped: rd_data_val_o=0.

## Configuration
- HEAD_TABLE_WR_BYPASS_EN defined: a same-cycle write and read to the same address returns the new write data. This is done by a registered compare of the addresses plus a write-data capture register and an output mux.
- HEAD_TABLE_WR_BYPASS_EN undefined: the same-cycle case returns the old RAM contents (read-before-write). No bypass logic is instantiated.

## Structure
- Shared package hash_table_pkg holds:
  - BUCKET_WIDTH and HEAD_PTR_WIDTH defaults.
  - typedef head_ram_data_t, a packed struct {ptr_val, ptr}.
  - The FSM state enum head_table_state_t {INIT, READY}.
- Sub-module head_ram: a simple dual-port RAM with one write port and one registered read port. It is parameterised by address width and data width and infers block RAM. head_table holds the FSM, the init counter, the write mux (sweep vs external) and the optional bypass.

## Test plan
Bench uses BUCKET_WIDTH=4, HEAD_PTR_WIDTH=10.
- Reset sweep: release rst_i, then read every bucket 0..15 once ready_o=1.
  - ready_o must rise exactly 16 cycles after rst_i deasserts.
  - All 16 reads must return ptr_val=0 with ptr=0.
- Write/read: write bucket 5 with ptr 0x2A3, val=1; read bucket 5 in the next cycle.
  - One cycle later rd_data_val_o=1, ptr=0x2A3, val=1.
- Same-cycle collision: bucket 7 holds 0x011/1; in one cycle, write 0x155/1 and read bucket 7.
  - With the macro: the read returns 0x155.
  - Without the macro: the read returns 0x011.
- Strobes during INIT: assert wr_en_i (bucket 3, 0x3FF/1) and rd_en_i during the sweep.
  - rd_data_val_o must stay 0.
  - After ready_o=1, bucket 3 must read val=0.
- Mid-operation reset: write bucket 9 with 0x100/1, pulse rst_i for 1 cycle while a read is in flight.
  - rd_data_val_o must be 0 and ready_o must drop for 16 cycles.
  - Afterwards bucket 9 must read val=0.
- Back-to-back throughput: one write and one read per cycle to random buckets for 1000 cycles.
  - Every read must match a reference model and be qualified by rd_data_val_o exactly one cycle later.
